tdc_pd_bin: RTL
===============

// Module: tdc_pd_bin
// PURPOSE
//  Parametrised binary-output TDC phase detector for the ADPLL loop.
//  - Measures the time between clk_ref and freq_div rising edges in clk periods.
//  - Reports the result as a signed, saturated phase error with a valid/ready handshake.
//  - Replaces the free-running thermometer PD; feeds the digital loop filter directly.
// PARAMETERS
//  CNT_W        5   counter width; max magnitude MAXC = 2**CNT_W-1
//  SYNC_STAGES  2   synchroniser flops on clk_ref and freq_div (min 2)
// PORTS
//  clk        in   1        sampling/TDC clock
//  reset      in   1        asynchronous, active-low reset (0 = reset)
//  clk_ref    in   1        reference clock, asynchronous to clk
//  freq_div   in   1        divided DCO clock, asynchronous to clk
//  err_ready  in   1        loop filter accepts phase_err
//  phase_err  out  CNT_W+1  signed error: +N = ref leads by N clk, -N = div leads
//  err_valid  out  1        phase_err holds an unaccepted result
//  lead       out  1        1 = ref led in the current result, 0 = div led or tie
//  sat        out  1        current result was clamped or cycle-slipped
//  overrun    out  1        an unaccepted result was overwritten
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = IDLE, counter 0, synchroniser flops 0.
//    Reset mid-measurement discards the measurement.
//  - Input path: clk_ref/freq_div pass through SYNC_STAGES flops, then a registered
//    rising-edge detect, giving ref_rise/div_rise one-cycle pulses.
//  - Measurement FSM:
//    - IDLE:
//      - ref_rise & div_rise -> result 0, complete, stay IDLE.
//      - ref_rise only -> LEAD_REF, cnt=1.
//      - div_rise only -> LEAD_DIV, cnt=1.
//    - LEAD_REF:
//      - div_rise -> result +cnt, complete, go IDLE. A ref_rise in the same cycle is ignored.
//      - ref_rise alone (cycle slip) -> result +MAXC, sat=1, complete, go IDLE.
//      - Otherwise cnt increments, saturating at MAXC. Sticky clamp sets sat on completion.
//    - LEAD_DIV: mirror of LEAD_REF with negative result.
//  - Result: N = cycles between ref_rise and div_rise detection.
//    - Magnitude clamps to MAXC, never wraps. Two's complement in CNT_W+1 bits.
//    - Result is never -2**CNT_W.
//  - Completion (one-cycle latency): on the clock edge after the closing edge pulse:
//    - phase_err/lead/sat load and err_valid=1.
//    - If err_valid was already 1 and not accepted, overrun=1.
//  - Handshake: transfer when err_valid & err_ready.
//    - The cycle after transfer: err_valid=0 and overrun=0.
//    - phase_err holds its value until the next completion.
//    - Completion in the same cycle as a transfer loads the new result, keeps err_valid=1
//      and does not set overrun.
//  - FSM never stalls on err_ready; measurements continue regardless of the consumer.
//  - End-to-end latency from the closing async edge: SYNC_STAGES+2 clk cycles.
// CONFIGURATION
//  - THERMO_OUT_EN defined: adds ports up_therm and dwn_therm.
//    - Width: out, 2**CNT_W-1 bits each.
//    - Loaded at completion with the thermometer code of |result|, k LSBs set.
//      up_therm is used for positive results, dwn_therm for negative; the other is 0.
//    - Both are 0 on reset and on a tie.
//    - Gives legacy loop-filter compatibility.
//  - THERMO_OUT_EN undefined: ports and logic absent; binary path unchanged.
// TESTING (CNT_W=5, SYNC_STAGES=2)
//  1. ref edge, div edge 7 clk later, err_ready=1 -> phase_err=+7, lead=1, sat=0,
//     err_valid for 1 cycle.
//  2. div leads by 12 clk -> phase_err=-12 (6'b110100), lead=0, sat=0.
//  3. Same-cycle edges -> phase_err=0, lead=0. Ref leads by 40 -> phase_err=+31, sat=1.
//     Two ref edges, no div -> +31, sat=1.
//  4. err_ready=0 over results +3 then -5 -> phase_err=-5, overrun=1, err_valid=1.
//     Raise err_ready -> next cycle err_valid=0, overrun=0.
//  5. reset=0 for 1 cycle mid LEAD_REF -> all outputs 0. Next ref/div pair at 4 clk -> +4.
//  6. THERMO_OUT_EN: +7 -> up_therm=0x0000007F, dwn_therm=0. -3 -> dwn_therm=0x7, up_therm=0.

Source files
------------

// File: rtl/tdc_pd_bin.sv
// Binary-output TDC phase detector: signed saturated ref/div edge offset in clk periods.
// Optional THERMO_OUT_EN adds legacy up_therm/dwn_therm thermometer outputs.
module tdc_pd_bin #(
   parameter int CNT_W       = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_ref,
   input  logic                    freq_div,
   input  logic                    err_ready,
   output logic signed [CNT_W:0]   phase_err,
   output logic                    err_valid,
   output logic                    lead,
   output logic                    sat,
   output logic                    overrun
`ifdef THERMO_OUT_EN
   ,
   output logic [2**CNT_W-2:0]     up_therm,
   output logic [2**CNT_W-2:0]     dwn_therm
`endif
);

   localparam int TW = 2**CNT_W - 1;
   localparam logic [CNT_W-1:0] MAXC = '1;

   typedef enum logic [1:0] {
      IDLE,
      LEAD_REF,
      LEAD_DIV
   } state_t;

   logic [SYNC_STAGES-1:0] ref_sync, div_sync;
   logic ref_last, div_last, ref_rise, div_rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ref_sync <= '0;
         div_sync <= '0;
         ref_last <= 1'b0;
         div_last <= 1'b0;
         ref_rise <= 1'b0;
         div_rise <= 1'b0;
      end else begin
         ref_sync <= {ref_sync[SYNC_STAGES-2:0], clk_ref};
         div_sync <= {div_sync[SYNC_STAGES-2:0], freq_div};
         ref_last <= ref_sync[SYNC_STAGES-1];
         div_last <= div_sync[SYNC_STAGES-1];
         ref_rise <= ref_sync[SYNC_STAGES-1] & ~ref_last;
         div_rise <= div_sync[SYNC_STAGES-1] & ~div_last;
      end
   end

   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic clamp_q, clamp_d;
   logic done, res_neg, res_sat;
   logic [CNT_W-1:0] res_mag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         clamp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clamp_q <= clamp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clamp_d = clamp_q;
      done    = 1'b0;
      res_neg = 1'b0;
      res_sat = 1'b0;
      res_mag = '0;
      unique case (state_q)
         IDLE: begin
            if (ref_rise && div_rise) begin
               done = 1'b1;
            end else if (ref_rise) begin
               state_d = LEAD_REF;
               cnt_d   = CNT_W'(1);
               clamp_d = 1'b0;
            end else if (div_rise) begin
               state_d = LEAD_DIV;
               cnt_d   = CNT_W'(1);
               clamp_d = 1'b0;
            end
         end
         LEAD_REF: begin
            if (div_rise) begin
               done    = 1'b1;
               res_mag = cnt_q;
               res_sat = clamp_q;
               state_d = IDLE;
            end else if (ref_rise) begin
               done    = 1'b1;
               res_mag = MAXC;
               res_sat = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == MAXC) begin
               clamp_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LEAD_DIV: begin
            res_neg = 1'b1;
            if (ref_rise) begin
               done    = 1'b1;
               res_mag = cnt_q;
               res_sat = clamp_q;
               state_d = IDLE;
            end else if (div_rise) begin
               done    = 1'b1;
               res_mag = MAXC;
               res_sat = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == MAXC) begin
               clamp_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   logic [CNT_W:0] mag_x;
   logic [CNT_W:0] res;
   logic           lead_n;

   assign mag_x  = {1'b0, res_mag};
   assign res    = res_neg ? -mag_x : mag_x;
   assign lead_n = ~res_neg & (res_mag != '0);

`ifdef THERMO_OUT_EN
   logic [TW-1:0] therm;

   always_comb begin
      therm = '0;
      for (int i = 0; i < TW; i++) begin
         therm[i] = (res_mag > CNT_W'(i));
      end
   end
`endif

   // Consumer never stalls measurement; an unaccepted result is overwritten.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_err <= '0;
         err_valid <= 1'b0;
         lead      <= 1'b0;
         sat       <= 1'b0;
         overrun   <= 1'b0;
`ifdef THERMO_OUT_EN
         up_therm  <= '0;
         dwn_therm <= '0;
`endif
      end else if (done) begin
         phase_err <= res;
         err_valid <= 1'b1;
         lead      <= lead_n;
         sat       <= res_sat;
         overrun   <= err_valid & ~err_ready;
`ifdef THERMO_OUT_EN
         up_therm  <= res_neg ? '0 : therm;
         dwn_therm <= res_neg ? therm : '0;
`endif
      end else if (err_valid && err_ready) begin
         err_valid <= 1'b0;
         overrun   <= 1'b0;
      end
   end

endmodule
